tree_deserializer: RTL

TREE_DESERIALIZER -- requirements
Module: tree_deserializer

---
 rtl/tree_deser_pkg.sv | 13 +
 rtl/deser_sync_detect.sv | 38 +++
 rtl/tree_deserializer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/tree_deser_pkg.sv
// rtl/tree_deser_pkg.sv - shared state encoding and default sync word for the tree deserializer
// Also importable by the serializer-side test pattern generator so both ends agree on the sync word.
package tree_deser_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } deser_state_e;

    localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hBC;

endpackage

// File: rtl/deser_sync_detect.sv
// rtl/deser_sync_detect.sv - LSB-first serial shift register with sync pattern compare
// Ports:
//   clk_i    : bit-rate clock (rising edge)
//   rst_ni   : asynchronous active-low reset, clears the shift register
//   serial_i : serial input bit, sampled every edge
//   word_o   : shift register contents including the bit being sampled this cycle
//   match_o  : word_o equals PATTERN
module deser_sync_detect #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] PATTERN = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             serial_i,
    output logic [WIDTH-1:0] word_o,
    output logic             match_o
);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;

    // New bits enter at the MSB so that after WIDTH shifts the first bit of a
    // word sits in bit 0.
    assign shift_d = {serial_i, shift_q[WIDTH-1:1]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    // Compare against the next-state value so the just-sampled bit counts.
    assign word_o  = shift_d;
    assign match_o = (shift_d == PATTERN);

endmodule

// File: rtl/tree_deserializer.sv
// rtl/tree_deserializer.sv - serial-to-parallel deserializer with sync-word alignment and lock FSM
// Ports:
//   CLK       : bit-rate clock, rising edge
//   RESET     : asynchronous active-low reset
//   SERIAL_IN : serial stream, LSB of each word first
//   RESYNC    : synchronous request to drop lock and hunt again
//   PAR_OUT   : recovered data word, held between PAR_VALID pulses
//   PAR_VALID : one-cycle pulse when PAR_OUT carries a new data word
//   LOCKED    : high while the FSM is locked
//   SYNC_ERR  : one-cycle pulse when lock is lost by sync timeout
module tree_deserializer
    import tree_deser_pkg::*;
#(
    parameter int                     OUTPUTS_NUM  = 8,
    parameter logic [OUTPUTS_NUM-1:0] SYNC_WORD    = OUTPUTS_NUM'(DEFAULT_SYNC_WORD),
    parameter int                     LOCK_CONFIRM = 2,
    parameter int                     SYNC_TIMEOUT = 64
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   SERIAL_IN,
    input  logic                   RESYNC,
    output logic [OUTPUTS_NUM-1:0] PAR_OUT,
    output logic                   PAR_VALID,
    output logic                   LOCKED,
    output logic                   SYNC_ERR
);

    localparam int BW = (OUTPUTS_NUM > 1) ? $clog2(OUTPUTS_NUM) : 1;
    localparam int CW = $clog2(LOCK_CONFIRM + 1);
    localparam int TW = $clog2(SYNC_TIMEOUT + 1);

    localparam logic [BW-1:0] LAST_BIT       = BW'(OUTPUTS_NUM - 1);
    localparam logic [CW-1:0] CONFIRM_TARGET = CW'(LOCK_CONFIRM);
    localparam logic [TW-1:0] TIMEOUT_LIMIT  = TW'(SYNC_TIMEOUT);

    logic [OUTPUTS_NUM-1:0] word;
    logic                   match;

    deser_state_e           state_q,     state_d;
    logic [BW-1:0]          bit_cnt_q,   bit_cnt_d;
    logic [CW-1:0]          conf_cnt_q,  conf_cnt_d;
    logic [TW-1:0]          to_cnt_q,    to_cnt_d;
    logic [OUTPUTS_NUM-1:0] par_out_q,   par_out_d;
    logic                   par_valid_q, par_valid_d;
    logic                   sync_err_q,  sync_err_d;
    logic                   locked_q;

    logic                   boundary;
    logic [TW-1:0]          to_next;

    deser_sync_detect #(
        .WIDTH   (OUTPUTS_NUM),
        .PATTERN (SYNC_WORD)
    ) u_sync_detect (
        .clk_i    (CLK),
        .rst_ni   (RESET),
        .serial_i (SERIAL_IN),
        .word_o   (word),
        .match_o  (match)
    );

    // A boundary is the cycle in which the last bit of an aligned word is sampled.
    assign boundary = (bit_cnt_q == LAST_BIT);
    assign to_next  = (to_cnt_q == TIMEOUT_LIMIT) ? to_cnt_q : to_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        conf_cnt_d  = conf_cnt_q;
        to_cnt_d    = to_cnt_q;
        par_out_d   = par_out_q;
        par_valid_d = 1'b0;
        sync_err_d  = 1'b0;

        if (state_q != ST_HUNT) begin
            bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
        end

        if (RESYNC) begin
            // Overrides any boundary action in the same cycle.
            state_d    = ST_HUNT;
            conf_cnt_d = '0;
            to_cnt_d   = '0;
        end else begin
            case (state_q)
                ST_HUNT: begin
                    if (match) begin
                        bit_cnt_d = '0;
                        to_cnt_d  = '0;
                        if (LOCK_CONFIRM == 1) begin
                            conf_cnt_d = CONFIRM_TARGET;
                            state_d    = ST_LOCKED;
                        end else begin
                            conf_cnt_d = CW'(1);
                            state_d    = ST_CONFIRM;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (boundary) begin
                        if (match) begin
                            conf_cnt_d = conf_cnt_q + 1'b1;
                            if (conf_cnt_q + 1'b1 == CONFIRM_TARGET) begin
                                state_d  = ST_LOCKED;
                                to_cnt_d = '0;
                            end
                        end else begin
                            conf_cnt_d = '0;
                            state_d    = ST_HUNT;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (boundary) begin
                        if (match) begin
                            // A sync at the timeout boundary still counts as a sync.
                            to_cnt_d = '0;
                        end else if (to_next == TIMEOUT_LIMIT) begin
                            state_d    = ST_HUNT;
                            sync_err_d = 1'b1;
                            to_cnt_d   = '0;
                            conf_cnt_d = '0;
                        end else begin
                            to_cnt_d    = to_next;
                            par_out_d   = word;
                            par_valid_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_HUNT;
            bit_cnt_q   <= '0;
            conf_cnt_q  <= '0;
            to_cnt_q    <= '0;
            par_out_q   <= '0;
            par_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            conf_cnt_q  <= conf_cnt_d;
            to_cnt_q    <= to_cnt_d;
            par_out_q   <= par_out_d;
            par_valid_q <= par_valid_d;
            sync_err_q  <= sync_err_d;
            locked_q    <= (state_d == ST_LOCKED);
        end
    end

    assign PAR_OUT   = par_out_q;
    assign PAR_VALID = par_valid_q;
    assign LOCKED    = locked_q;
    assign SYNC_ERR  = sync_err_q;

endmodule
